// File: rtl/tester_pkg.sv
// tester_pkg
// Shared types and bus-geometry constants for the trace tester driver and
// the tester tile. Also supplies default values for the trace/MAC width
// macros when the surrounding build has not defined them.
//   op_e    : command opcode (write / read)
//   state_e : trace_tester_driver FSM states
//   BYTES   : bytes per MAC interface beat
//   L       : log2(BYTES), used to turn byte counts into beat counts

`ifndef TRACE_ADDR_W
`define TRACE_ADDR_W 32
`endif
`ifndef TRACE_SIZE_W
`define TRACE_SIZE_W 16
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 256
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 5
`endif

package tester_pkg;

    localparam int BYTES = `MAC_INTERFACE_W / 8;
    localparam int L     = $clog2(BYTES);

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_DATA,
        RD_REQ,
        RD_CHECK,
        DONE
    } state_e;

endpackage

// File: rtl/trace_beat_calc.sv
// trace_beat_calc
// Combinational conversion of a byte count into the number of MAC beats it
// occupies and the number of unused bytes in the final beat.
//   size     in  byte count
//   beats    out ceil(size / BYTES), one bit wider than size so the largest
//                size cannot wrap
//   padbytes out unused bytes in the final beat (0 when size is a multiple
//                of BYTES)

module trace_beat_calc
    import tester_pkg::*;
(
    input  logic [`TRACE_SIZE_W-1:0]   size,
    output logic [`TRACE_SIZE_W:0]     beats,
    output logic [`MAC_PADBYTES_W-1:0] padbytes
);

    logic [`TRACE_SIZE_W:0] size_ext;
    logic [L-1:0]           rem;

    // The pad count is (BYTES - rem) mod BYTES, which is just the L-bit
    // two's-complement negation of the remainder.
    always_comb begin
        size_ext = {1'b0, size};
        beats    = (size_ext + (`TRACE_SIZE_W+1)'(BYTES - 1)) >> L;
        rem      = size[L-1:0];
        padbytes = `MAC_PADBYTES_W'(L'(L'(0) - rem));
    end

endmodule

// File: rtl/trace_tester_driver.sv
// trace_tester_driver
// Pops commands and data lines from the trace sources, issues write
// requests with framed payload beats, issues read requests and checks every
// returned beat against the expected line from the data source.
//   clk, rst                       clock, async active-high reset
//   cmd_*                          command handshake and fields
//   src_data_*                     trace data lines (write payload or
//                                  expected read data)
//   trace_tester_tile_wr_mem_req_* write request to the tile
//   trace_tester_tile_data_*       write payload beats to the tile
//   trace_tester_tile_rd_mem_req_* read request to the tile
//   tester_tile_trace_data_*       read data beats from the tile
//   test_done/test_pass/test_timeout/err_cnt  run status

module trace_tester_driver
    import tester_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int ERR_CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         cmd_val,
    output logic                         cmd_rdy,
    input  logic                         cmd_op,
    input  logic [`TRACE_ADDR_W-1:0]     cmd_addr,
    input  logic [`TRACE_SIZE_W-1:0]     cmd_size,
    input  logic                         cmd_last,

    input  logic                         src_data_val,
    output logic                         src_data_rdy,
    input  logic [`MAC_INTERFACE_W-1:0]  src_data,

    output logic                         trace_tester_tile_wr_mem_req_val,
    output logic [`TRACE_ADDR_W-1:0]     trace_tester_tile_wr_mem_req_addr,
    output logic [`TRACE_SIZE_W-1:0]     trace_tester_tile_wr_mem_req_size,
    input  logic                         tester_tile_trace_wr_mem_req_rdy,

    output logic                         trace_tester_tile_data_val,
    output logic [`MAC_INTERFACE_W-1:0]  trace_tester_tile_data_data,
    output logic                         trace_tester_tile_data_last,
    output logic [`MAC_PADBYTES_W-1:0]   trace_tester_tile_data_padbytes,
    input  logic                         tester_tile_trace_data_rdy,

    output logic                         trace_tester_tile_rd_mem_req_val,
    output logic [`TRACE_ADDR_W-1:0]     trace_tester_tile_rd_mem_req_addr,
    output logic [`TRACE_SIZE_W-1:0]     trace_tester_tile_rd_mem_req_size,
    input  logic                         tester_tile_trace_rd_mem_req_rdy,

    input  logic                         tester_tile_trace_data_val,
    input  logic [`MAC_INTERFACE_W-1:0]  tester_tile_trace_data_data,
    input  logic                         tester_tile_trace_data_last,
    input  logic [`MAC_PADBYTES_W-1:0]   tester_tile_trace_data_padbytes,
    output logic                         trace_tester_tile_data_rdy,

    output logic                         test_done,
    output logic                         test_pass,
    output logic                         test_timeout,
    output logic [ERR_CNT_W-1:0]         err_cnt
);

    localparam int DW   = `MAC_INTERFACE_W;
    localparam int SW   = `TRACE_SIZE_W;
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e                      state_q, state_d;
    logic [`TRACE_ADDR_W-1:0]    addr_q, addr_d;
    logic [SW-1:0]               size_q, size_d;
    logic                        last_q, last_d;
    logic [SW:0]                 beats_q, beats_d;
    logic [SW:0]                 beat_cnt_q, beat_cnt_d;
    logic [`MAC_PADBYTES_W-1:0]  pad_q, pad_d;
    logic [ERR_CNT_W-1:0]        err_cnt_q, err_cnt_d;
    logic [WD_W-1:0]             wd_q, wd_d;
    logic                        timeout_q, timeout_d;

    logic [SW:0]                 calc_beats;
    logic [`MAC_PADBYTES_W-1:0]  calc_pad;

    logic                        is_final;
    logic [DW-1:0]               line_mask;
    logic                        beat_err;
    logic [ERR_CNT_W-1:0]        err_cnt_inc;
    logic                        any_hs;

    trace_beat_calc u_beat_calc (
        .size     (cmd_size),
        .beats    (calc_beats),
        .padbytes (calc_pad)
    );

    // State and latched command fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            last_q     <= 1'b0;
            beats_q    <= '0;
            beat_cnt_q <= '0;
            pad_q      <= '0;
            err_cnt_q  <= '0;
            wd_q       <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            last_q     <= last_d;
            beats_q    <= beats_d;
            beat_cnt_q <= beat_cnt_d;
            pad_q      <= pad_d;
            err_cnt_q  <= err_cnt_d;
            wd_q       <= wd_d;
            timeout_q  <= timeout_d;
        end
    end

    // Output decode, read-beat compare, next-state and watchdog.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        last_d     = last_q;
        beats_d    = beats_q;
        beat_cnt_d = beat_cnt_q;
        pad_d      = pad_q;
        err_cnt_d  = err_cnt_q;
        wd_d       = wd_q;
        timeout_d  = timeout_q;

        cmd_rdy                          = 1'b0;
        src_data_rdy                     = 1'b0;
        trace_tester_tile_wr_mem_req_val = 1'b0;
        trace_tester_tile_rd_mem_req_val = 1'b0;
        trace_tester_tile_data_val       = 1'b0;
        trace_tester_tile_data_last      = 1'b0;
        trace_tester_tile_data_padbytes  = '0;
        trace_tester_tile_data_rdy       = 1'b0;

        trace_tester_tile_wr_mem_req_addr = addr_q;
        trace_tester_tile_wr_mem_req_size = size_q;
        trace_tester_tile_rd_mem_req_addr = addr_q;
        trace_tester_tile_rd_mem_req_size = size_q;
        trace_tester_tile_data_data       = src_data;

        test_done    = (state_q == DONE);
        test_pass    = (state_q == DONE) && (err_cnt_q == '0) && !timeout_q;
        test_timeout = timeout_q;
        err_cnt      = err_cnt_q;

        is_final    = (beat_cnt_q == beats_q - (SW+1)'(1));
        err_cnt_inc = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);

        // The low padbytes of the final beat carry no payload, so they are
        // cleared on both sides before comparing.
        line_mask = is_final ? ({DW{1'b1}} << {pad_q, 3'b000}) : {DW{1'b1}};
        beat_err  = ((src_data & line_mask) != (tester_tile_trace_data_data & line_mask))
                  || (tester_tile_trace_data_last != is_final)
                  || (is_final && (tester_tile_trace_data_padbytes != pad_q));

        case (state_q)
            IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_val) begin
                    addr_d     = cmd_addr;
                    size_d     = cmd_size;
                    last_d     = cmd_last;
                    beats_d    = calc_beats;
                    pad_d      = calc_pad;
                    beat_cnt_d = '0;
                    if (cmd_size == '0) begin
                        err_cnt_d = err_cnt_inc;
                        state_d   = cmd_last ? DONE : IDLE;
                    end else if (op_e'(cmd_op) == OP_READ) begin
                        state_d = RD_REQ;
                    end else begin
                        state_d = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                trace_tester_tile_wr_mem_req_val = 1'b1;
                if (tester_tile_trace_wr_mem_req_rdy) begin
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                trace_tester_tile_data_val      = src_data_val;
                src_data_rdy                    = tester_tile_trace_data_rdy;
                trace_tester_tile_data_last     = is_final;
                trace_tester_tile_data_padbytes = is_final ? pad_q : '0;
                if (src_data_val && tester_tile_trace_data_rdy) begin
                    beat_cnt_d = beat_cnt_q + (SW+1)'(1);
                    if (is_final) begin
                        state_d = last_q ? DONE : IDLE;
                    end
                end
            end
            RD_REQ: begin
                trace_tester_tile_rd_mem_req_val = 1'b1;
                if (tester_tile_trace_rd_mem_req_rdy) begin
                    state_d = RD_CHECK;
                end
            end
            RD_CHECK: begin
                trace_tester_tile_data_rdy = src_data_val;
                src_data_rdy               = tester_tile_trace_data_val;
                if (src_data_val && tester_tile_trace_data_val) begin
                    beat_cnt_d = beat_cnt_q + (SW+1)'(1);
                    if (beat_err) begin
                        err_cnt_d = err_cnt_inc;
                    end
                    // Leave on the beat we expected to be final, whatever
                    // the tile claimed with its last flag.
                    if (is_final) begin
                        state_d = last_q ? DONE : IDLE;
                    end
                end
            end
            DONE: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        any_hs = (cmd_val && cmd_rdy)
              || (src_data_val && src_data_rdy)
              || (trace_tester_tile_wr_mem_req_val && tester_tile_trace_wr_mem_req_rdy)
              || (trace_tester_tile_rd_mem_req_val && tester_tile_trace_rd_mem_req_rdy)
              || (trace_tester_tile_data_val && tester_tile_trace_data_rdy)
              || (tester_tile_trace_data_val && trace_tester_tile_data_rdy);

        // Watchdog: counts stalled cycles while a transfer is in flight and
        // overrides the FSM into DONE when the budget runs out.
        if ((state_q == IDLE) || (state_q == DONE) || any_hs) begin
            wd_d = '0;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            wd_d      = '0;
            timeout_d = 1'b1;
            state_d   = DONE;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end
    end

endmodule

// File: tb/tb_trace_tester_driver.sv
// tb_trace_tester_driver
// Directed bench for trace_tester_driver on a 256-bit (32-byte) bus with a
// 16-cycle watchdog. Each scenario task drives the DUT from negedge to
// negedge and checks outputs 1 time unit after inputs settle.

module tb_trace_tester_driver;

    localparam int DW = `MAC_INTERFACE_W;
    localparam int AW = `TRACE_ADDR_W;
    localparam int SW = `TRACE_SIZE_W;
    localparam int PW = `MAC_PADBYTES_W;

    logic          clk;
    logic          rst;
    logic          cmd_val;
    logic          cmd_rdy;
    logic          cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [SW-1:0] cmd_size;
    logic          cmd_last;
    logic          src_data_val;
    logic          src_data_rdy;
    logic [DW-1:0] src_data;
    logic          wr_req_val;
    logic [AW-1:0] wr_req_addr;
    logic [SW-1:0] wr_req_size;
    logic          wr_req_rdy;
    logic          out_val;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [PW-1:0] out_pad;
    logic          out_rdy;
    logic          rd_req_val;
    logic [AW-1:0] rd_req_addr;
    logic [SW-1:0] rd_req_size;
    logic          rd_req_rdy;
    logic          in_val;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic [PW-1:0] in_pad;
    logic          in_rdy;
    logic          test_done;
    logic          test_pass;
    logic          test_timeout;
    logic [15:0]   err_cnt;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] wlines   [0:7];
    logic [DW-1:0] exp_lines[0:7];
    logic [DW-1:0] ret_lines[0:7];

    trace_tester_driver #(
        .TIMEOUT_CYCLES (16),
        .ERR_CNT_W      (16)
    ) dut (
        .clk                               (clk),
        .rst                               (rst),
        .cmd_val                           (cmd_val),
        .cmd_rdy                           (cmd_rdy),
        .cmd_op                            (cmd_op),
        .cmd_addr                          (cmd_addr),
        .cmd_size                          (cmd_size),
        .cmd_last                          (cmd_last),
        .src_data_val                      (src_data_val),
        .src_data_rdy                      (src_data_rdy),
        .src_data                          (src_data),
        .trace_tester_tile_wr_mem_req_val  (wr_req_val),
        .trace_tester_tile_wr_mem_req_addr (wr_req_addr),
        .trace_tester_tile_wr_mem_req_size (wr_req_size),
        .tester_tile_trace_wr_mem_req_rdy  (wr_req_rdy),
        .trace_tester_tile_data_val        (out_val),
        .trace_tester_tile_data_data       (out_data),
        .trace_tester_tile_data_last       (out_last),
        .trace_tester_tile_data_padbytes   (out_pad),
        .tester_tile_trace_data_rdy        (out_rdy),
        .trace_tester_tile_rd_mem_req_val  (rd_req_val),
        .trace_tester_tile_rd_mem_req_addr (rd_req_addr),
        .trace_tester_tile_rd_mem_req_size (rd_req_size),
        .tester_tile_trace_rd_mem_req_rdy  (rd_req_rdy),
        .tester_tile_trace_data_val        (in_val),
        .tester_tile_trace_data_data       (in_data),
        .tester_tile_trace_data_last       (in_last),
        .tester_tile_trace_data_padbytes   (in_pad),
        .trace_tester_tile_data_rdy        (in_rdy),
        .test_done                         (test_done),
        .test_pass                         (test_pass),
        .test_timeout                      (test_timeout),
        .err_cnt                           (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Deterministic, non-trivial 256-bit pattern per seed.
    function automatic logic [DW-1:0] make_line(input int seed);
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) begin
            r[i*32 +: 32] = 32'(seed) * 32'h9E3779B1 + 32'(i) * 32'h01010101 + 32'h5A;
        end
        return r;
    endfunction

    // All-ones with the low pb bytes cleared.
    function automatic logic [DW-1:0] keep_mask(input int pb);
        logic [DW-1:0] m;
        m = '1;
        m = m << (pb * 8);
        return m;
    endfunction

    task automatic idle_inputs();
        cmd_val      = 1'b0;
        cmd_op       = 1'b0;
        cmd_addr     = '0;
        cmd_size     = '0;
        cmd_last     = 1'b0;
        src_data_val = 1'b0;
        src_data     = '0;
        wr_req_rdy   = 1'b0;
        out_rdy      = 1'b0;
        rd_req_rdy   = 1'b0;
        in_val       = 1'b0;
        in_data      = '0;
        in_last      = 1'b0;
        in_pad       = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Enters and leaves just after a negedge; the command is accepted on
    // the posedge in between (DUT is in IDLE with cmd_rdy high).
    task automatic send_cmd(input logic op, input logic [AW-1:0] a,
                            input logic [SW-1:0] s, input logic l);
        cmd_val  = 1'b1;
        cmd_op   = op;
        cmd_addr = a;
        cmd_size = s;
        cmd_last = l;
        @(posedge clk);
        @(negedge clk);
        cmd_val = 1'b0;
    endtask

    // Full write transfer from wlines[0..nb-1], checking request and beats.
    task automatic drive_write(input logic [AW-1:0] a, input logic [SW-1:0] s,
                               input logic l, input int nb, input int pb,
                               input string tag);
        logic [PW-1:0] exp_pad;
        logic          exp_last;
        send_cmd(1'b0, a, s, l);
        #1;
        checks++;
        if (wr_req_val !== 1'b1 || wr_req_addr !== a || wr_req_size !== s || cmd_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_wr_req: val=%b addr=%h size=%0d cmd_rdy=%b, required val=1 addr=%h size=%0d cmd_rdy=0",
                     tag, wr_req_val, wr_req_addr, wr_req_size, cmd_rdy, a, s);
        end
        wr_req_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr_req_rdy = 1'b0;
        for (int b = 0; b < nb; b++) begin
            src_data_val = 1'b1;
            src_data     = wlines[b];
            out_rdy      = 1'b1;
            exp_last     = (b == nb - 1);
            exp_pad      = exp_last ? PW'(pb) : '0;
            #1;
            checks++;
            if (out_val !== 1'b1 || out_data !== wlines[b] || out_last !== exp_last ||
                out_pad !== exp_pad || src_data_rdy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s_beat%0d: val=%b last=%b pad=%0d src_rdy=%b data=%h, required val=1 last=%b pad=%0d src_rdy=1 data=%h",
                         tag, b, out_val, out_last, out_pad, src_data_rdy, out_data, exp_last, exp_pad, wlines[b]);
            end
            @(posedge clk);
            @(negedge clk);
        end
        src_data_val = 1'b0;
        out_rdy      = 1'b0;
    endtask

    // Full read transfer: expected lines from exp_lines, tile returns
    // ret_lines. flip_beat flips bit 7 of that returned beat; last_beat is
    // the beat on which the tile raises last (normally nb-1).
    task automatic drive_read(input logic [AW-1:0] a, input logic [SW-1:0] s,
                              input logic l, input int nb, input int pb,
                              input int flip_beat, input int last_beat,
                              input string tag);
        logic [DW-1:0] flip;
        send_cmd(1'b1, a, s, l);
        #1;
        checks++;
        if (rd_req_val !== 1'b1 || rd_req_addr !== a || rd_req_size !== s || wr_req_val !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_rd_req: val=%b addr=%h size=%0d wr_val=%b, required val=1 addr=%h size=%0d wr_val=0",
                     tag, rd_req_val, rd_req_addr, rd_req_size, wr_req_val, a, s);
        end
        rd_req_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_req_rdy = 1'b0;
        for (int b = 0; b < nb; b++) begin
            flip         = '0;
            flip[7]      = (b == flip_beat);
            src_data_val = 1'b1;
            src_data     = exp_lines[b];
            in_val       = 1'b1;
            in_data      = ret_lines[b] ^ flip;
            in_last      = (b == last_beat) || (b == nb - 1);
            in_pad       = (b == nb - 1) ? PW'(pb) : '0;
            #1;
            checks++;
            if (in_rdy !== 1'b1 || src_data_rdy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s_rd_beat%0d: data_rdy=%b src_rdy=%b, required data_rdy=1 src_rdy=1",
                         tag, b, in_rdy, src_data_rdy);
            end
            @(posedge clk);
            @(negedge clk);
        end
        src_data_val = 1'b0;
        in_val       = 1'b0;
        in_last      = 1'b0;
        in_pad       = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #1;
        checks++;
        if (cmd_rdy !== 1'b1 || wr_req_val !== 1'b0 || rd_req_val !== 1'b0 || out_val !== 1'b0 ||
            in_rdy !== 1'b0 || src_data_rdy !== 1'b0 || test_done !== 1'b0 || test_pass !== 1'b0 ||
            test_timeout !== 1'b0 || err_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_values: cmd_rdy=%b wr=%b rd=%b dval=%b drdy=%b srdy=%b done=%b pass=%b to=%b err=%0d, required 1 0 0 0 0 0 0 0 0 0",
                     cmd_rdy, wr_req_val, rd_req_val, out_val, in_rdy, src_data_rdy,
                     test_done, test_pass, test_timeout, err_cnt);
        end
        do_reset();
        #1;
        checks++;
        if (cmd_rdy !== 1'b1 || test_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: cmd_rdy=%b done=%b, required cmd_rdy=1 done=0", cmd_rdy, test_done);
        end
    endtask

    task automatic test_write_64();
        do_reset();
        wlines[0] = make_line(1);
        wlines[1] = make_line(2);
        drive_write(32'h100, 16'd64, 1'b0, 2, 0, "wr64");
        #1;
        checks++;
        if (cmd_rdy !== 1'b1 || err_cnt !== 16'd0 || test_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wr64_end: cmd_rdy=%b err=%0d done=%b, required cmd_rdy=1 err=0 done=0",
                     cmd_rdy, err_cnt, test_done);
        end
    endtask

    task automatic test_loopback_70();
        do_reset();
        wlines[0] = make_line(3);
        wlines[1] = make_line(4);
        wlines[2] = make_line(5) & keep_mask(26);
        drive_write(32'h200, 16'd70, 1'b0, 3, 26, "wr70");
        for (int b = 0; b < 3; b++) begin
            exp_lines[b] = wlines[b];
            ret_lines[b] = wlines[b];
        end
        exp_lines[2] = wlines[2] | (make_line(77) & ~keep_mask(26));
        drive_read(32'h200, 16'd70, 1'b1, 3, 26, -1, 2, "rd70");
        #1;
        checks++;
        if (err_cnt !== 16'd0 || test_done !== 1'b1 || test_pass !== 1'b1 || test_timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rd70_result: err=%0d done=%b pass=%b to=%b, required err=0 done=1 pass=1 to=0",
                     err_cnt, test_done, test_pass, test_timeout);
        end
        checks++;
        if (cmd_rdy !== 1'b0 || in_rdy !== 1'b0 || rd_req_val !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_outputs: cmd_rdy=%b data_rdy=%b rd_val=%b, required 0 0 0",
                     cmd_rdy, in_rdy, rd_req_val);
        end
    endtask

    task automatic test_read_mismatch();
        do_reset();
        exp_lines[0] = make_line(20);
        exp_lines[1] = make_line(21) & keep_mask(24);
        ret_lines[0] = exp_lines[0];
        ret_lines[1] = exp_lines[1];
        drive_read(32'h240, 16'd40, 1'b1, 2, 24, 0, 0, "rd40");
        #1;
        checks++;
        if (err_cnt !== 16'd1 || test_done !== 1'b1 || test_pass !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rd40_result: err=%0d done=%b pass=%b, required err=1 done=1 pass=0",
                     err_cnt, test_done, test_pass);
        end
    endtask

    task automatic test_timeout_run();
        do_reset();
        send_cmd(1'b1, 32'h300, 16'd32, 1'b0);
        repeat (15) @(negedge clk);
        #1;
        checks++;
        if (test_done !== 1'b0 || test_timeout !== 1'b0 || rd_req_val !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_early: done=%b to=%b rd_val=%b, required done=0 to=0 rd_val=1",
                     test_done, test_timeout, rd_req_val);
        end
        @(negedge clk);
        #1;
        checks++;
        if (test_done !== 1'b1 || test_timeout !== 1'b1 || test_pass !== 1'b0 || rd_req_val !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_fire: done=%b to=%b pass=%b rd_val=%b, required done=1 to=1 pass=0 rd_val=0",
                     test_done, test_timeout, test_pass, rd_req_val);
        end
    endtask

    task automatic test_size_zero();
        do_reset();
        send_cmd(1'b0, 32'h400, 16'd0, 1'b1);
        #1;
        checks++;
        if (wr_req_val !== 1'b0 || rd_req_val !== 1'b0 || err_cnt !== 16'd1 ||
            test_done !== 1'b1 || test_pass !== 1'b0) begin
            errors++;
            $display("[TB] FAIL size0: wr=%b rd=%b err=%0d done=%b pass=%b, required wr=0 rd=0 err=1 done=1 pass=0",
                     wr_req_val, rd_req_val, err_cnt, test_done, test_pass);
        end
        cmd_val = 1'b1;
        repeat (3) @(negedge clk);
        cmd_val = 1'b0;
        #1;
        checks++;
        if (test_done !== 1'b1 || cmd_rdy !== 1'b0 || wr_req_val !== 1'b0 || err_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL done_sticky: done=%b cmd_rdy=%b wr=%b err=%0d, required done=1 cmd_rdy=0 wr=0 err=1",
                     test_done, cmd_rdy, wr_req_val, err_cnt);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        for (int b = 0; b < 4; b++) wlines[b] = make_line(40 + b);
        send_cmd(1'b0, 32'h500, 16'd128, 1'b0);
        wr_req_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr_req_rdy   = 1'b0;
        src_data_val = 1'b1;
        src_data     = wlines[0];
        out_rdy      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        src_data = wlines[1];
        #1;
        checks++;
        if (out_val !== 1'b1 || out_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_beat2: val=%b last=%b, required val=1 last=0", out_val, out_last);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (out_val !== 1'b0 || src_data_rdy !== 1'b0 || cmd_rdy !== 1'b1 ||
            wr_req_val !== 1'b0 || out_pad !== '0 || err_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: val=%b srdy=%b cmd_rdy=%b wr=%b pad=%0d err=%0d, required 0 0 1 0 0 0",
                     out_val, src_data_rdy, cmd_rdy, wr_req_val, out_pad, err_cnt);
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        send_cmd(1'b0, 32'h600, 16'd32, 1'b0);
        #1;
        checks++;
        if (wr_req_val !== 1'b1 || wr_req_addr !== 32'h600 || wr_req_size !== 16'd32) begin
            errors++;
            $display("[TB] FAIL post_reset_cmd: val=%b addr=%h size=%0d, required val=1 addr=600 size=32",
                     wr_req_val, wr_req_addr, wr_req_size);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_write_64();
        test_loopback_70();
        test_read_mismatch();
        test_timeout_run();
        test_size_zero();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
